// File: rtl/control_sequencer.sv
// control_sequencer: registered control sequencer between decoder and datapath.
// Latency: a word accepted at edge N drives the outputs after edge N. Memory-class
//   words stay visible for MEM_LATENCY+1 cycles, and write-back is enabled only in the last.
// Backpressure: in_ready is low during RST, WAIT and HALT. Words offered then are ignored.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      decoder handshake; a word is taken when both are high
//   in_alu .. in_mux         pre-decoded control fields
//   in_branch, in_halt, take branch/halt qualifiers; take is sampled only on accept
//   controlALU .. controlMUX registered control word presented to the datapath
//   enable                   PC / pipeline advance enable
//   busy                     memory wait in progress
//   halted                   halt latched (cleared only by reset)
module control_sequencer #(
  parameter int ALU_W       = 4,
  parameter int BS_W        = 4,
  parameter int SEL_W       = 3,
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ALU_W-1:0] in_alu,
  input  logic [BS_W-1:0]  in_bs,
  input  logic [SEL_W-1:0] in_rb,
  input  logic [SEL_W-1:0] in_se1,
  input  logic [SEL_W-1:0] in_se2,
  input  logic [SEL_W-1:0] in_mah,
  input  logic [SEL_W-1:0] in_mdh,
  input  logic [SEL_W-1:0] in_em,
  input  logic             in_mux,
  input  logic             in_branch,
  input  logic             in_halt,
  input  logic             take,
  output logic [ALU_W-1:0] controlALU,
  output logic [BS_W-1:0]  controlBS,
  output logic [SEL_W-1:0] controlRB,
  output logic [SEL_W-1:0] controlSE1,
  output logic [SEL_W-1:0] controlSE2,
  output logic [SEL_W-1:0] controlMAH,
  output logic [SEL_W-1:0] controlMDH,
  output logic [SEL_W-1:0] controlEM,
  output logic             controlMUX,
  output logic             enable,
  output logic             busy,
  output logic             halted
);

  // Full control word, kept as one packed record so that hold/replace is a single assignment.
  typedef struct packed {
    logic [ALU_W-1:0] alu;
    logic [BS_W-1:0]  bs;
    logic [SEL_W-1:0] rb;
    logic [SEL_W-1:0] se1;
    logic [SEL_W-1:0] se2;
    logic [SEL_W-1:0] mah;
    logic [SEL_W-1:0] mdh;
    logic [SEL_W-1:0] em;
    logic             mux;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // EM=0 means "no memory access". EM=7 is the idle/reset encoding. Every other EM value is a memory access.
  localparam logic [SEL_W-1:0] EM_IDLE = SEL_W'(7);
  localparam logic [SEL_W-1:0] RB_RST  = SEL_W'(5);
  localparam logic [ALU_W-1:0] ALU_NOP = ALU_W'(12);
  localparam bit               HAS_WAIT = (MEM_LATENCY != 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);

  localparam ctrl_t RESET_WORD = '{
    alu: '0, bs: '0, rb: RB_RST, se1: '0, se2: '0,
    mah: '0, mdh: '0, em: EM_IDLE, mux: 1'b0
  };

  localparam ctrl_t NOP_WORD = '{
    alu: ALU_NOP, bs: '0, rb: '0, se1: '0, se2: '0,
    mah: '0, mdh: '0, em: '0, mux: 1'b0
  };

  state_t           state_q, state_d;
  ctrl_t            word_q, word_d;
  logic             enable_q, enable_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // The real register-bank select of a memory word. It is suppressed during the wait and restored in the last cycle.
  logic [SEL_W-1:0] rb_hold_q, rb_hold_d;

  ctrl_t in_word;
  logic  accept;
  logic  is_mem;
  logic  wait_last;

  always_comb begin
    in_word     = '0;
    in_word.alu = in_alu;
    in_word.bs  = in_bs;
    in_word.rb  = in_rb;
    in_word.se1 = in_se1;
    in_word.se2 = in_se2;
    in_word.mah = in_mah;
    in_word.mdh = in_mdh;
    in_word.em  = in_em;
    in_word.mux = in_mux;
    // An untaken branch must not redirect the memory address handler.
    if (in_branch && !take) begin
      in_word.mah = '0;
    end
  end

  assign in_ready  = (state_q == ST_ISSUE);
  assign accept    = in_valid && in_ready;
  assign is_mem    = (in_em != '0) && (in_em != EM_IDLE);
  // The WAIT cycle whose edge moves the counter to zero produces the final, write-enabled cycle.
  assign wait_last = (cnt_q <= CNT_W'(1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RST:   state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (accept) begin
          if (in_halt) begin
            state_d = ST_HALT;
          end else if (is_mem && HAS_WAIT) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_WAIT:  state_d = wait_last ? ST_ISSUE : ST_WAIT;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RST;
    endcase
  end

  // Output / datapath next-value logic. Every output is registered from these values.
  always_comb begin
    word_d    = word_q;
    enable_d  = enable_q;
    busy_d    = busy_q;
    halted_d  = halted_q;
    cnt_d     = cnt_q;
    rb_hold_d = rb_hold_q;
    unique case (state_q)
      ST_RST: begin
        word_d   = NOP_WORD;
        enable_d = 1'b1;
        busy_d   = 1'b0;
        halted_d = 1'b0;
        cnt_d    = '0;
      end
      ST_ISSUE: begin
        busy_d = 1'b0;
        if (!accept) begin
          word_d   = NOP_WORD;
          enable_d = 1'b1;
        end else if (in_halt) begin
          // Halt has priority over the memory class: no wait, and the PC freezes at once.
          word_d    = in_word;
          word_d.rb = '0;
          enable_d  = 1'b0;
          halted_d  = 1'b1;
        end else if (is_mem && HAS_WAIT) begin
          word_d    = in_word;
          word_d.rb = '0;
          rb_hold_d = in_rb;
          enable_d  = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = CNT_LOAD;
        end else begin
          word_d   = in_word;
          enable_d = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        if (wait_last) begin
          word_d.rb = rb_hold_q;
          enable_d  = 1'b1;
          busy_d    = 1'b0;
        end
      end
      ST_HALT: begin
        enable_d = 1'b0;
        halted_d = 1'b1;
      end
      default: begin
        word_d = RESET_WORD;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      word_q    <= RESET_WORD;
      enable_q  <= 1'b1;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      cnt_q     <= '0;
      rb_hold_q <= '0;
    end else begin
      word_q    <= word_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      cnt_q     <= cnt_d;
      rb_hold_q <= rb_hold_d;
    end
  end

  assign controlALU = word_q.alu;
  assign controlBS  = word_q.bs;
  assign controlRB  = word_q.rb;
  assign controlSE1 = word_q.se1;
  assign controlSE2 = word_q.se2;
  assign controlMAH = word_q.mah;
  assign controlMDH = word_q.mdh;
  assign controlEM  = word_q.em;
  assign controlMUX = word_q.mux;
  assign enable     = enable_q;
  assign busy       = busy_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer at its default parameters (MEM_LATENCY=2).
// It drives inputs on the falling edge and samples outputs on the next falling edge.
module tb_control_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_alu, in_bs;
  logic [2:0] in_rb, in_se1, in_se2, in_mah, in_mdh, in_em;
  logic       in_mux, in_branch, in_halt, take;
  logic [3:0] controlALU, controlBS;
  logic [2:0] controlRB, controlSE1, controlSE2, controlMAH, controlMDH, controlEM;
  logic       controlMUX, enable, busy, halted;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu(in_alu), .in_bs(in_bs), .in_rb(in_rb), .in_se1(in_se1), .in_se2(in_se2),
    .in_mah(in_mah), .in_mdh(in_mdh), .in_em(in_em), .in_mux(in_mux),
    .in_branch(in_branch), .in_halt(in_halt), .take(take),
    .controlALU(controlALU), .controlBS(controlBS), .controlRB(controlRB),
    .controlSE1(controlSE1), .controlSE2(controlSE2), .controlMAH(controlMAH),
    .controlMDH(controlMDH), .controlEM(controlEM), .controlMUX(controlMUX),
    .enable(enable), .busy(busy), .halted(halted)
  );

  typedef struct {
    string name;
    int    valid, alu, rb, mah, em, mux, branch, tk;
    int    e_alu, e_rb, e_mah, e_em, e_mux, e_en, e_busy, e_rdy;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_alu = 0; in_bs = 0; in_rb = 0; in_se1 = 0; in_se2 = 0;
    in_mah = 0; in_mdh = 0; in_em = 0; in_mux = 0; in_branch = 0; in_halt = 0; take = 0;
  endtask

  task automatic chk_word(input string tag, input int alu, input int rb, input int mah,
                          input int em, input int en, input int bsy, input int hlt);
    chk({tag, ".alu"},    int'(controlALU), alu);
    chk({tag, ".rb"},     int'(controlRB), rb);
    chk({tag, ".mah"},    int'(controlMAH), mah);
    chk({tag, ".em"},     int'(controlEM), em);
    chk({tag, ".enable"}, int'(enable), en);
    chk({tag, ".busy"},   int'(busy), bsy);
    chk({tag, ".halted"}, int'(halted), hlt);
  endtask

  initial begin
    //           name      vld alu rb mah em mux br tk | e_alu e_rb e_mah e_em e_mux en busy rdy
    vecs[0] = '{"alu5",     1,  5, 1, 0, 0, 1, 0, 0,   5,  1, 0, 0, 1, 1, 0, 1};
    vecs[1] = '{"nop",      0,  9, 4, 3, 2, 1, 0, 0,  12,  0, 0, 0, 0, 1, 0, 1};
    vecs[2] = '{"br_ntk",   1,  3, 2, 6, 0, 0, 1, 0,   3,  2, 0, 0, 0, 1, 0, 1};
    vecs[3] = '{"br_tk",    1,  3, 2, 6, 0, 0, 1, 1,   3,  2, 6, 0, 0, 1, 0, 1};
    vecs[4] = '{"nobr_mah", 1,  7, 1, 4, 0, 0, 0, 0,   7,  1, 4, 0, 0, 1, 0, 1};
    vecs[5] = '{"em7_idle", 1,  2, 4, 0, 7, 1, 0, 0,   2,  4, 0, 7, 1, 1, 0, 1};

    idle_inputs();
    reset = 1;
    repeat (3) step();
    chk_word("rst", 0, 5, 0, 7, 1, 0, 0);
    chk("rst.ready", int'(in_ready), 0);

    // The reset word stays for exactly one cycle after release, and then NOP follows.
    reset = 0;
    #1;
    chk_word("rst_hold", 0, 5, 0, 7, 1, 0, 0);
    chk("rst_hold.ready", int'(in_ready), 0);
    @(negedge clock);
    step();
    chk_word("first_nop", 12, 0, 0, 0, 1, 0, 0);
    chk("first_nop.ready", int'(in_ready), 1);

    // Single-cycle words in ISSUE
    foreach (vecs[i]) begin
      in_valid = 1'(vecs[i].valid); in_alu = 4'(vecs[i].alu); in_rb = 3'(vecs[i].rb);
      in_mah = 3'(vecs[i].mah); in_em = 3'(vecs[i].em); in_mux = 1'(vecs[i].mux);
      in_branch = 1'(vecs[i].branch); take = 1'(vecs[i].tk);
      step();
      chk({vecs[i].name, ".alu"},   int'(controlALU), vecs[i].e_alu);
      chk({vecs[i].name, ".rb"},    int'(controlRB),  vecs[i].e_rb);
      chk({vecs[i].name, ".mah"},   int'(controlMAH), vecs[i].e_mah);
      chk({vecs[i].name, ".em"},    int'(controlEM),  vecs[i].e_em);
      chk({vecs[i].name, ".mux"},   int'(controlMUX), vecs[i].e_mux);
      chk({vecs[i].name, ".en"},    int'(enable),     vecs[i].e_en);
      chk({vecs[i].name, ".busy"},  int'(busy),       vecs[i].e_busy);
      chk({vecs[i].name, ".ready"}, int'(in_ready),   vecs[i].e_rdy);
    end
    idle_inputs();
    step();

    // A load waits 2 cycles with RB suppressed. Inputs offered during the wait are ignored.
    in_valid = 1; in_em = 6; in_mdh = 6; in_mah = 5; in_rb = 3; in_alu = 1;
    step();
    in_alu = 9; in_rb = 7; in_em = 0; take = 1;
    for (int c = 1; c <= 2; c++) begin
      chk_word($sformatf("load_w%0d", c), 1, 0, 5, 6, 0, 1, 0);
      chk($sformatf("load_w%0d.mdh", c), int'(controlMDH), 6);
      chk($sformatf("load_w%0d.ready", c), int'(in_ready), 0);
      step();
    end
    chk_word("load_last", 1, 3, 5, 6, 1, 0, 0);
    idle_inputs();
    step();
    chk_word("load_after", 12, 0, 0, 0, 1, 0, 0);
    chk("load_after.ready", int'(in_ready), 1);

    // An untaken memory-class branch: take rising during the wait must not restore MAH.
    in_valid = 1; in_branch = 1; take = 0; in_mah = 6; in_em = 1; in_rb = 2; in_alu = 4;
    step();
    take = 1; in_valid = 0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("brmem_c%0d.mah", c), int'(controlMAH), 0);
      if (c < 3) step();
    end
    chk("brmem_last.rb", int'(controlRB), 2);
    idle_inputs();
    step();

    // A halt on a memory-class word halts without waiting, and later words are ignored.
    in_valid = 1; in_halt = 1; in_alu = 8; in_rb = 3; in_em = 2;
    step();
    chk_word("halt", 8, 0, 0, 2, 0, 0, 1);
    chk("halt.ready", int'(in_ready), 0);
    in_halt = 0;
    for (int c = 0; c < 10; c++) begin
      in_alu = 4'(c); in_rb = 3'(c); in_em = 0;
      step();
      if (controlALU != 4'd8 || enable != 1'b0 || halted != 1'b1 || in_ready != 1'b0) begin
        chk($sformatf("halt_hold%0d", c), {int'(controlALU), int'(enable), int'(halted)}, 0);
      end else begin
        checks++;
      end
    end
    in_valid = 0;
    reset = 1;
    step();
    chk_word("halt_rst", 0, 5, 0, 7, 1, 0, 0);
    reset = 0;
    step();
    step();
    chk_word("halt_rel", 12, 0, 0, 0, 1, 0, 0);

    // Reset in the first WAIT cycle drops the load, and the load is not replayed afterwards.
    in_valid = 1; in_em = 5; in_rb = 7; in_alu = 1;
    step();
    chk("midwait.busy", int'(busy), 1);
    idle_inputs();
    reset = 1;
    step();
    chk_word("midwait_rst", 0, 5, 0, 7, 1, 0, 0);
    reset = 0;
    step();
    step();
    chk_word("midwait_nop1", 12, 0, 0, 0, 1, 0, 0);
    step();
    chk_word("midwait_nop2", 12, 0, 0, 0, 1, 0, 0);
    chk("midwait_nop2.ready", int'(in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
